// File: rtl/dft_bin_correlator.sv
// Two-bin real-input DFT correlator: mixes samples against NCO phasors, then emits |X|^2 per bin.
// Optional DFT_LOG2_OUT_EN: power outputs become 9-bit {msb_index[5:0], mantissa[2:0]}.
module dft_bin_correlator #(
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned PH_W      = 18,
    parameter int unsigned N_SAMPLES = 256,
    parameter int unsigned ACC_W     = 26,
`ifdef DFT_LOG2_OUT_EN
    localparam int unsigned POW_W    = 9
`else
    localparam int unsigned POW_W    = 2 * ACC_W + 1
`endif
) (
    input  logic                CK,
    input  logic                RST_N,
    input  logic                START,
    output logic                nco_start,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [PH_W-1:0]     cos0,
    input  logic [PH_W-1:0]     sin0,
    input  logic [PH_W-1:0]     cos1,
    input  logic [PH_W-1:0]     sin1,
    output logic                ready,
    output logic                out_valid,
    output logic [POW_W-1:0]    power0,
    output logic [POW_W-1:0]    power1
);

    localparam int unsigned FULL_W = 2 * ACC_W + 1;
    localparam int unsigned PROD_W = SAMPLE_W + PH_W;
    localparam int unsigned CNT_W  = $clog2(N_SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCUM, S_SQ0, S_SQ1, S_SQ2, S_SQ3, S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   re0_q, re0_d, im0_q, im0_d;
    logic signed [ACC_W-1:0]   re1_q, re1_d, im1_q, im1_d;
    logic [FULL_W-1:0]         sum_q, sum_d;
    logic [POW_W-1:0]          stage0_q, stage0_d;
    logic [POW_W-1:0]          power0_q, power0_d, power1_q, power1_d;
    logic                      out_valid_q, out_valid_d;
    logic                      ready_q, ready_d;
    logic                      nco_start_q, nco_start_d;

    logic signed [PROD_W-1:0]  p_c0, p_s0, p_c1, p_s1;
    logic signed [ACC_W-1:0]   sq_op;
    logic signed [2*ACC_W-1:0] sq_full;
    logic [FULL_W-1:0]         sq_u;
    logic                      accept;

    // Power format for the output registers; identity unless the log2 encoding is built in.
    function automatic logic [POW_W-1:0] to_pow(input logic [FULL_W-1:0] p);
`ifdef DFT_LOG2_OUT_EN
        logic [5:0]        e;
        logic [FULL_W+2:0] sh;
        e = '0;
        for (int i = 0; i < int'(FULL_W); i++) begin
            if (p[i]) e = 6'(i);
        end
        // Appending three zeros makes e<3 zero-fill the mantissa naturally.
        sh = {p, 3'b000} >> e;
        return (p == '0) ? '0 : {e, sh[2:0]};
`else
        return p;
`endif
    endfunction

    assign p_c0 = PROD_W'($signed(sample)) * PROD_W'($signed(cos0));
    assign p_s0 = PROD_W'($signed(sample)) * PROD_W'($signed(sin0));
    assign p_c1 = PROD_W'($signed(sample)) * PROD_W'($signed(cos1));
    assign p_s1 = PROD_W'($signed(sample)) * PROD_W'($signed(sin1));

    // Single shared squarer, operand selected by the SQ state.
    assign sq_full = (2*ACC_W)'(sq_op) * (2*ACC_W)'(sq_op);
    assign sq_u    = FULL_W'($unsigned(sq_full));

    assign accept = (state_q == S_ACCUM) && ready_q && sample_valid && !START;

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            re0_q       <= '0;
            im0_q       <= '0;
            re1_q       <= '0;
            im1_q       <= '0;
            sum_q       <= '0;
            stage0_q    <= '0;
            power0_q    <= '0;
            power1_q    <= '0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            nco_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            re0_q       <= re0_d;
            im0_q       <= im0_d;
            re1_q       <= re1_d;
            im1_q       <= im1_d;
            sum_q       <= sum_d;
            stage0_q    <= stage0_d;
            power0_q    <= power0_d;
            power1_q    <= power1_d;
            out_valid_q <= out_valid_d;
            ready_q     <= ready_d;
            nco_start_q <= nco_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        re0_d       = re0_q;
        im0_d       = im0_q;
        re1_d       = re1_q;
        im1_d       = im1_q;
        sum_d       = sum_q;
        stage0_d    = stage0_q;
        power0_d    = power0_q;
        power1_d    = power1_q;
        out_valid_d = 1'b0;
        nco_start_d = START;
        sq_op       = re0_q;

        if (START) begin
            // START aborts anything in flight, including a pending out_valid.
            state_d = S_ACCUM;
            cnt_d   = '0;
            re0_d   = '0;
            im0_d   = '0;
            re1_d   = '0;
            im1_d   = '0;
            sum_d   = '0;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    if (accept) begin
                        re0_d = re0_q + ACC_W'(p_c0 >>> (PH_W - 1));
                        im0_d = im0_q - ACC_W'(p_s0 >>> (PH_W - 1));
                        re1_d = re1_q + ACC_W'(p_c1 >>> (PH_W - 1));
                        im1_d = im1_q - ACC_W'(p_s1 >>> (PH_W - 1));
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(N_SAMPLES - 1)) state_d = S_SQ0;
                    end
                end
                S_SQ0: begin
                    sq_op   = re0_q;
                    sum_d   = sq_u;
                    state_d = S_SQ1;
                end
                S_SQ1: begin
                    sq_op    = im0_q;
                    stage0_d = to_pow(sum_q + sq_u);
                    state_d  = S_SQ2;
                end
                S_SQ2: begin
                    sq_op   = re1_q;
                    sum_d   = sq_u;
                    state_d = S_SQ3;
                end
                S_SQ3: begin
                    sq_op       = im1_q;
                    power0_d    = stage0_q;
                    power1_d    = to_pow(sum_q + sq_u);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign ready_d   = (state_d == S_ACCUM);
    assign nco_start = nco_start_q;
    assign ready     = ready_q;
    assign out_valid = out_valid_q;
    assign power0    = power0_q;
    assign power1    = power1_q;

endmodule

// File: tb/tb_dft_bin_correlator.sv
// Scoreboard bench for dft_bin_correlator with N_SAMPLES=4; follows DFT_LOG2_OUT_EN if defined.
module tb_dft_bin_correlator;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned PH_W     = 18;
    localparam int unsigned NS       = 4;
    localparam int unsigned ACC_W    = 26;
`ifdef DFT_LOG2_OUT_EN
    localparam int unsigned POW_W    = 9;
`else
    localparam int unsigned POW_W    = 2 * ACC_W + 1;
`endif

    logic                CK = 1'b0;
    logic                RST_N = 1'b0;
    logic                START = 1'b0;
    logic                nco_start;
    logic                sample_valid = 1'b0;
    logic [SAMPLE_W-1:0] sample = '0;
    logic [PH_W-1:0]     cos0 = '0, sin0 = '0, cos1 = '0, sin1 = '0;
    logic                ready, out_valid;
    logic [POW_W-1:0]    power0, power1;

    dft_bin_correlator #(
        .SAMPLE_W(SAMPLE_W), .PH_W(PH_W), .N_SAMPLES(NS), .ACC_W(ACC_W)
    ) dut (
        .CK(CK), .RST_N(RST_N), .START(START), .nco_start(nco_start),
        .sample_valid(sample_valid), .sample(sample),
        .cos0(cos0), .sin0(sin0), .cos1(cos1), .sin1(sin1),
        .ready(ready), .out_valid(out_valid), .power0(power0), .power1(power1)
    );

    always #5 CK = ~CK;

    typedef struct packed {
        logic [63:0] p0;
        logic [63:0] p1;
    } exp_t;

    exp_t   sb_q[$];
    int     checks = 0;
    int     failures = 0;
    int     ov_count = 0;
    int     frames_done = 0;
    time    last_acc_time = 0;
    longint m_re0, m_im0, m_re1, m_im1;
    int     m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint fmt_pow(input longint p);
`ifdef DFT_LOG2_OUT_EN
        int e;
        longint f;
        if (p == 0) return 0;
        e = 63;
        while (((p >> e) & 1) == 0) e--;
        f = (e >= 3) ? ((p >> (e - 3)) & 7) : ((p << (3 - e)) & 7);
        return (longint'(e) << 3) | f;
`else
        return p;
`endif
    endfunction

    always @(negedge CK) begin
        if (out_valid) begin
            exp_t e;
            ov_count++;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("power0", 64'(power0), e.p0);
                check_eq("power1", 64'(power1), e.p1);
                check_eq("ov_latency", 64'($time - last_acc_time), 64'd45);
            end
        end
    end

    task automatic do_start(input logic with_sample);
        START = 1'b1;
        sample_valid = with_sample;
        sample = 16'd12345;
        cos0 = 18'h1ffff;
        @(posedge CK); #1;
        START = 1'b0;
        sample_valid = 1'b0;
        m_re0 = 0; m_im0 = 0; m_re1 = 0; m_im1 = 0; m_cnt = 0;
        check_eq("nco_start", 64'(nco_start), 64'd1);
        check_eq("ready_after_start", 64'(ready), 64'd1);
    endtask

    task automatic send(input int s, input int c0, input int s0, input int c1, input int s1,
                        input int gap);
        int w;
        w = 0;
        while (!ready && w < 50) begin
            @(posedge CK); #1;
            w++;
        end
        if (!ready) check_eq("ready_timeout", 64'(ready), 64'd1);
        sample = 16'(s);
        cos0 = 18'(c0); sin0 = 18'(s0); cos1 = 18'(c1); sin1 = 18'(s1);
        sample_valid = 1'b1;
        @(posedge CK);
        last_acc_time = $time;
        #1 sample_valid = 1'b0;
        m_re0 += (longint'(s) * longint'(c0)) >>> 17;
        m_im0 -= (longint'(s) * longint'(s0)) >>> 17;
        m_re1 += (longint'(s) * longint'(c1)) >>> 17;
        m_im1 -= (longint'(s) * longint'(s1)) >>> 17;
        m_cnt++;
        if (m_cnt == NS) begin
            exp_t e;
            e.p0 = 64'(fmt_pow(m_re0 * m_re0 + m_im0 * m_im0));
            e.p1 = 64'(fmt_pow(m_re1 * m_re1 + m_im1 * m_im1));
            sb_q.push_back(e);
            frames_done++;
        end
        repeat (gap) begin
            @(posedge CK); #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge CK);
        if (sb_q.size() != 0) check_eq("out_valid_timeout", 64'(sb_q.size()), 64'd0);
        repeat (2) @(posedge CK);
        #1;
    endtask

    initial begin
        m_re0 = 0; m_im0 = 0; m_re1 = 0; m_im1 = 0; m_cnt = 0;
        repeat (3) @(posedge CK);
        #1;
        check_eq("rst_power0", 64'(power0), 64'd0);
        check_eq("rst_power1", 64'(power1), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_ready", 64'(ready), 64'd0);
        check_eq("rst_nco_start", 64'(nco_start), 64'd0);
        RST_N = 1'b1;
        @(posedge CK); #1;

        // Case 1: unit cosine on bin 0
        do_start(1'b0);
        for (int i = 0; i < 4; i++) send(1000, 131071, 0, -65536, 65536, 0);
        sample_valid = 1'b1;
        drain();
        sample_valid = 1'b0;
`ifndef DFT_LOG2_OUT_EN
        check_eq("case1_power0_const", 64'(power0), 64'd15968016);
`endif

        // Case 2: negative sample against unit sine
        do_start(1'b0);
        for (int i = 0; i < 4; i++) send(-1000, 0, 131071, 65536, 0, 0);
        drain();
`ifdef DFT_LOG2_OUT_EN
        check_eq("case2_log2_const", 64'(power0), 64'd191);
`else
        check_eq("case2_power0_const", 64'(power0), 64'd16000000);
`endif

        // Case 3: restart mid-frame
        do_start(1'b0);
        for (int i = 0; i < 2; i++) send(777, 5000, -9000, 1234, 4321, 0);
        do_start(1'b0);
        for (int i = 0; i < 4; i++) send(1000, 131071, 0, 0, 0, 0);
        drain();

        // Case 4: gapped samples, START carrying a sample_valid that must be dropped
        do_start(1'b1);
        for (int i = 0; i < 4; i++) send(1000, 131071, 0, -131072, 131071, 3);
        drain();

        // Case 5: reset during SQ2
        do_start(1'b0);
        for (int i = 0; i < 4; i++) send(-3000, 100000, -50000, 70000, 20000, 0);
        @(posedge CK);
        @(posedge CK); #1;
        RST_N = 1'b0;
        void'(sb_q.pop_back());
        frames_done--;
        @(posedge CK); #1;
        check_eq("rst_mid_power0", 64'(power0), 64'd0);
        check_eq("rst_mid_power1", 64'(power1), 64'd0);
        check_eq("rst_mid_ready", 64'(ready), 64'd0);
        RST_N = 1'b1;
        repeat (8) @(posedge CK);
        #1;
        check_eq("post_rst_ready", 64'(ready), 64'd0);
        check_eq("post_rst_power0", 64'(power0), 64'd0);

        // Random frames with random gaps
        for (int f = 0; f < 6; f++) begin
            do_start(f[0]);
            for (int i = 0; i < 4; i++) begin
                send(int'($signed(16'($urandom))), int'($signed(18'($urandom))),
                     int'($signed(18'($urandom))), int'($signed(18'($urandom))),
                     int'($signed(18'($urandom))), int'($urandom_range(0, 2)));
            end
            drain();
        end

        check_eq("out_valid_count", 64'(ov_count), 64'(frames_done));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
